// File: rtl/cla_serial_seq.sv
// cla_serial_seq: nibble-serial add/subtract sequencer driving one shared external Cla_4
module cla_serial_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       cla_x,
  output logic [3:0]       cla_y,
  output logic             cla_c0,
  input  logic [3:0]       cla_s,
  input  logic             cla_c4
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_serial_seq: WIDTH must be a multiple of 4 and at least 8");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry, sgn_b, last, run_en;
  logic [IW-1:0]    idx;
  assign last   = idx == IW'(NIB - 1);
  assign run_en = state == RUN && !rst;
  // next state and handshake / Cla_4 drive
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy    = state == RUN;
    done    = state == DONE;
    cla_x   = run_en ? a_r[4*idx +: 4] : 4'd0;
    cla_y   = run_en ? b_r[4*idx +: 4] : 4'd0;
    cla_c0  = run_en ? carry : 1'b0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // operand capture, slice-by-slice result assembly and carry chaining
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sgn_b <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      sgn_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      sum[4*idx +: 4] <= cla_s;
      carry           <= cla_c4;
      idx             <= last ? '0 : idx + IW'(1);
      if (last) begin
        cout <= cla_c4;
        ovf  <= (a_r[WIDTH-1] == sgn_b) && (cla_s[3] != a_r[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_seq.sv
// tb_cla_serial_seq: scoreboard bench for cla_serial_seq with a behavioural Cla_4 and reference model
module tb_cla_serial_seq;
  localparam int W = 16;
  logic         clk = 0, rst = 1, start = 0, sub = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         busy, done, cout, ovf, cla_c0, cla_c4;
  logic [3:0]   cla_x, cla_y, cla_s;
  int           checks = 0, errors = 0;
  logic [17:0]  exp_q[$];
  logic [17:0]  last_exp = '0;

  cla_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .cla_x(cla_x), .cla_y(cla_y), .cla_c0(cla_c0), .cla_s(cla_s), .cla_c4(cla_c4)
  );

  assign {cla_c4, cla_s} = 5'(cla_x) + 5'(cla_y) + 5'(cla_c0);

  always #5 clk = ~clk;

  function automatic logic [17:0] ref_op(input logic [15:0] ra, rb, input logic rc, rs);
    int sa, sb, r;
    logic [16:0] u;
    logic co;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (rs) begin
      r  = sa - sb;
      u  = {1'b0, ra} - {1'b0, rb};
      co = ra >= rb;
    end else begin
      r  = sa + sb + int'(rc);
      u  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      co = u[16];
    end
    return {u[15:0], co, (r > 32767 || r < -32768)};
  endfunction

  function automatic logic carry_into(input logic [15:0] ra, rb, input logic rc, rs, input int k);
    int m;
    if (k == 0) return rs ? 1'b1 : rc;
    m = (1 << (4 * k)) - 1;
    return rs ? ((int'(ra) & m) >= (int'(rb) & m)) : ((int'(ra) & m) + (int'(rb) & m) + int'(rc) > m);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({sum, cout, ovf} !== e) begin
          errors++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || done) && g < 50) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic do_op(input logic [15:0] ia, ib, input logic ic, is, input bit intr);
    int lat, bc, k;
    lat = 0; bc = 0; k = 0;
    wait_idle();
    a = ia; b = ib; cin = ic; sub = is; start = 1;
    last_exp = ref_op(ia, ib, ic, is);
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1;
    start = 0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    while (!done && lat < 20) begin
      if (busy) begin
        bc++;
        if (k < 4) chk($sformatf("cla_c0_slice%0d", k), 32'(cla_c0), 32'(carry_into(ia, ib, ic, is, k)));
        k++;
      end
      start = (intr && lat == 1);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 0;
    chk("latency", lat, 4);
    chk("busy_cycles", bc, 4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", 32'(sum), 0);
    chk("rst_flags", {busy, done, cout, ovf}, 0);
    chk("rst_cla", {cla_x, cla_y, cla_c0}, 0);
    @(negedge clk);
    rst = 0;
    do_op(16'h1234, 16'h4321, 0, 0, 0);
    do_op(16'hFFFF, 16'h0001, 0, 0, 0);
    do_op(16'h0006, 16'h0009, 1, 0, 0);
    do_op(16'h0005, 16'h0007, 1, 1, 0);
    do_op(16'h7FFF, 16'h0001, 0, 0, 0);
    do_op(16'h8000, 16'h0001, 0, 1, 0);
    do_op(16'h1111, 16'h2222, 0, 0, 1);
    do_op(16'hABCD, 16'h1234, 0, 1, 0);
    wait_idle();
    a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("abort_sum", 32'(sum), 0);
    chk("abort_flags", {busy, done, cout, ovf}, 0);
    chk("abort_cla", {cla_x, cla_y, cla_c0}, 0);
    @(negedge clk);
    rst = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle", {busy, done}, 0);
    do_op(16'h0F0F, 16'h00F1, 1, 0, 0);
    for (int i = 0; i < 40; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    do_op(16'h8000, 16'h8000, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("sum_held", {sum, cout, ovf}, 32'(last_exp));
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
